// File: rtl/misao_reg_stack.sv
// MISA-O register-stack unit: two banks (S/A) of DEPTH x WIDTH registers with
// accumulator swap, multi-step rotation and nibble rotate. Define MISAO_REGSTACK_ROTL_EN for op 101 ROTL.
module misao_reg_stack #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned NIB   = 4,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic             op_bank,
  input  logic [CW-1:0]    op_count,
  input  logic             lk_mode,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] acc_out,
  output logic             acc_we,
  output logic             done,
  output logic [WIDTH-1:0] top_s,
  output logic [WIDTH-1:0] top_a
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ROTATE = 1'b1;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SWAP  = 3'b001;
  localparam logic [2:0] OP_SWAPW = 3'b010;
  localparam logic [2:0] OP_ROT   = 3'b011;
  localparam logic [2:0] OP_RRR   = 3'b100;
  localparam logic [2:0] OP_ROTL  = 3'b101;

  localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'({NIB{1'b1}});

  logic [WIDTH-1:0] bank_s [DEPTH];
  logic [WIDTH-1:0] bank_a [DEPTH];
  logic [WIDTH-1:0] sel    [DEPTH];
  logic [WIDTH-1:0] step   [DEPTH];

  logic [0:0]       state, state_nxt;
  logic [CW-1:0]    rot_cnt, cnt_nxt;
  logic             rot_bank, rot_left;
  logic             cur_bank, cur_left;
  logic             accept;

  logic             top_we, step_we, we_nxt, done_nxt;
  logic [WIDTH-1:0] new_top, acc_nxt, top_rrr;

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign top_s    = bank_s[0];
  assign top_a    = bank_a[0];

  // Bank/direction come from the live op fields at accept, from the latched copy while rotating
  assign cur_bank = (state == ST_IDLE) ? op_bank : rot_bank;
  assign cur_left = (state == ST_IDLE) ? (op_code == OP_ROTL) : rot_left;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel[i] = cur_bank ? bank_a[i] : bank_s[i];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      step[i] = cur_left ? sel[(i + 1) % DEPTH] : sel[(i + DEPTH - 1) % DEPTH];
    end
  end

  assign top_rrr = (sel[0] >> NIB) | (sel[0] << (WIDTH - NIB));

  always_comb begin
    top_we    = 1'b0;
    step_we   = 1'b0;
    new_top   = sel[0];
    acc_nxt   = acc_out;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    state_nxt = state;
    cnt_nxt   = rot_cnt;
    if (state == ST_IDLE) begin
      if (accept) begin
        case (op_code)
          OP_SWAP: begin
            top_we   = 1'b1;
            we_nxt   = 1'b1;
            done_nxt = 1'b1;
            if (lk_mode) begin
              new_top = acc_in;
              acc_nxt = sel[0];
            end else begin
              new_top = (sel[0] & ~LANE_MASK) | (acc_in & LANE_MASK);
              acc_nxt = (acc_in & ~LANE_MASK) | (sel[0] & LANE_MASK);
            end
          end
          OP_SWAPW: begin
            top_we   = 1'b1;
            we_nxt   = 1'b1;
            done_nxt = 1'b1;
            new_top  = acc_in;
            acc_nxt  = sel[0];
          end
          OP_RRR: begin
            done_nxt = 1'b1;
            top_we   = !lk_mode;
            new_top  = top_rrr;
          end
`ifdef MISAO_REGSTACK_ROTL_EN
          OP_ROT, OP_ROTL: begin
`else
          OP_ROT: begin
`endif
            // First step happens on the accept edge; rot_cnt holds the steps still to go
            step_we   = 1'b1;
            state_nxt = ST_ROTATE;
            cnt_nxt   = op_count;
            done_nxt  = (op_count == '0);
          end
          default: done_nxt = 1'b1;
        endcase
      end
    end else begin
      if (rot_cnt != '0) begin
        step_we  = 1'b1;
        cnt_nxt  = rot_cnt - CW'(1);
        done_nxt = (rot_cnt == CW'(1));
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank_s[i] <= '0;
        bank_a[i] <= '0;
      end
      state    <= ST_IDLE;
      rot_cnt  <= '0;
      rot_bank <= 1'b0;
      rot_left <= 1'b0;
      acc_out  <= '0;
      acc_we   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rot_cnt <= cnt_nxt;
      acc_out <= acc_nxt;
      acc_we  <= we_nxt;
      done    <= done_nxt;
      if (accept) begin
        rot_bank <= op_bank;
        rot_left <= (op_code == OP_ROTL);
      end
      if (step_we) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (cur_bank) bank_a[i] <= step[i];
          else          bank_s[i] <= step[i];
        end
      end
      if (top_we) begin
        if (cur_bank) bank_a[0] <= new_top;
        else          bank_s[0] <= new_top;
      end
    end
  end

endmodule

// File: tb/tb_misao_reg_stack.sv
// Scoreboard bench for misao_reg_stack: DEPTH=2 and DEPTH=4 instances, directed ops,
// expected results queued at issue and checked by per-instance monitors on done.
module tb_misao_reg_stack;

`ifdef MISAO_REGSTACK_ROTL_EN
  localparam bit ROTL_ON = 1'b1;
`else
  localparam bit ROTL_ON = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'b000, SWAP = 3'b001, SWAPW = 3'b010, ROT = 3'b011,
                         RRR = 3'b100, ROTL = 3'b101;

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [15:0] acc;
    logic [15:0] ts;
    logic [15:0] ta;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q2[$];
  exp_t q4[$];

  logic        v2 = 0, b2 = 0, l2 = 0, r2, we2, dn2;
  logic [2:0]  c2 = '0;
  logic [0:0]  n2 = '0;
  logic [15:0] a2 = '0, ao2, ts2, ta2;
  logic        v4 = 0, b4 = 0, l4 = 0, r4, we4, dn4;
  logic [2:0]  c4 = '0;
  logic [1:0]  n4 = '0;
  logic [15:0] a4 = '0, ao4, ts4, ta4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  misao_reg_stack #(.WIDTH(16), .NIB(4), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .op_valid(v2), .op_ready(r2), .op_code(c2), .op_bank(b2),
    .op_count(n2), .lk_mode(l2), .acc_in(a2), .acc_out(ao2), .acc_we(we2), .done(dn2),
    .top_s(ts2), .top_a(ta2));

  misao_reg_stack #(.WIDTH(16), .NIB(4), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .op_valid(v4), .op_ready(r4), .op_code(c4), .op_bank(b4),
    .op_count(n4), .lk_mode(l4), .acc_in(a4), .acc_out(ao4), .acc_we(we4), .done(dn4),
    .top_s(ts4), .top_a(ta4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (dn2) begin
        if (q2.size() == 0) chk("d2_spurious_done", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          chk("d2_done_cycle", cyc, e.cyc);
          chk("d2_acc_we", {31'd0, we2}, {31'd0, e.we});
          chk("d2_acc_out", {16'd0, ao2}, {16'd0, e.acc});
          chk("d2_top_s", {16'd0, ts2}, {16'd0, e.ts});
          chk("d2_top_a", {16'd0, ta2}, {16'd0, e.ta});
        end
      end else if (we2) chk("d2_we_without_done", 32'd1, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (dn4) begin
        if (q4.size() == 0) chk("d4_spurious_done", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("d4_done_cycle", cyc, e.cyc);
          chk("d4_acc_we", {31'd0, we4}, {31'd0, e.we});
          chk("d4_acc_out", {16'd0, ao4}, {16'd0, e.acc});
          chk("d4_top_s", {16'd0, ts4}, {16'd0, e.ts});
          chk("d4_top_a", {16'd0, ta4}, {16'd0, e.ta});
        end
      end else if (we4) chk("d4_we_without_done", 32'd1, 32'd0);
    end
  end

  // Called on a negedge; issues one op, pushes its expectation, waits for op_ready again
  task automatic issue(input bit big, input logic [2:0] code, input logic bank,
                       input int unsigned cnt, input logic lk, input logic [15:0] acc,
                       input int unsigned k, input logic we, input logic [15:0] eacc,
                       input logic [15:0] ets, input logic [15:0] eta);
    exp_t e;
    bit ok;
    e.cyc = cyc + k; e.we = we; e.acc = eacc; e.ts = ets; e.ta = eta;
    if (big) begin
      q4.push_back(e);
      c4 = code; b4 = bank; n4 = cnt[1:0]; l4 = lk; a4 = acc; v4 = 1'b1;
    end else begin
      q2.push_back(e);
      c2 = code; b2 = bank; n2 = cnt[0:0]; l2 = lk; a2 = acc; v2 = 1'b1;
    end
    @(posedge clk);
    #1 v2 = 1'b0; v4 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((big ? r4 : r2) === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready2", {31'd0, r2}, 32'd1);
    chk("rst_done2", {31'd0, dn2}, 32'd0);
    chk("rst_we2", {31'd0, we2}, 32'd0);
    chk("rst_acc2", {16'd0, ao2}, 32'd0);
    chk("rst_tops2", {ts2, ta2}, 32'd0);
    chk("rst_tops4", {ts4, ta4}, 32'd0);
    chk("rst_ready4", {31'd0, r4}, 32'd1);

    // DEPTH=2: swaps, rotations, nibble rotate, reserved codes
    issue(0, SWAP,  0, 0, 0, 16'hAAA1, 1, 1, 16'hAAA0, 16'h0001, 16'h0000);
    issue(0, SWAPW, 1, 0, 0, 16'h0005, 1, 1, 16'h0000, 16'h0001, 16'h0005);
    issue(0, SWAPW, 1, 0, 0, 16'hAAA1, 1, 1, 16'h0005, 16'h0001, 16'hAAA1);
    issue(0, SWAP,  0, 0, 1, 16'hBBBB, 1, 1, 16'h0001, 16'hBBBB, 16'hAAA1);
    issue(0, ROT,   0, 0, 0, 16'hFFFF, 1, 0, 16'h0001, 16'h0000, 16'hAAA1);
    issue(0, ROT,   0, 1, 0, 16'hFFFF, 2, 0, 16'h0001, 16'h0000, 16'hAAA1);
    issue(0, ROT,   1, 0, 0, 16'hFFFF, 1, 0, 16'h0001, 16'h0000, 16'h0000);
    issue(0, ROT,   0, 0, 0, 16'hFFFF, 1, 0, 16'h0001, 16'hBBBB, 16'h0000);
    issue(0, SWAP,  0, 0, 1, 16'h0041, 1, 1, 16'hBBBB, 16'h0041, 16'h0000);
    issue(0, RRR,   0, 0, 0, 16'hFFFF, 1, 0, 16'hBBBB, 16'h1004, 16'h0000);
    issue(0, RRR,   0, 0, 1, 16'hFFFF, 1, 0, 16'hBBBB, 16'h1004, 16'h0000);
    issue(0, 3'b110, 0, 0, 0, 16'hFFFF, 1, 0, 16'hBBBB, 16'h1004, 16'h0000);
    issue(0, 3'b111, 1, 0, 1, 16'hFFFF, 1, 0, 16'hBBBB, 16'h1004, 16'h0000);
    issue(0, NOP,   0, 0, 0, 16'hFFFF, 1, 0, 16'hBBBB, 16'h1004, 16'h0000);
    issue(0, ROTL,  0, 1, 0, 16'hFFFF, ROTL_ON ? 2 : 1, 0, 16'hBBBB, 16'h1004, 16'h0000);
    issue(0, SWAP,  1, 0, 0, 16'h1234, 1, 1, 16'h1230, 16'h1004, 16'h0004);
    issue(0, RRR,   1, 0, 0, 16'hFFFF, 1, 0, 16'h1230, 16'h1004, 16'h4000);

    // DEPTH=4: build S = {1,2,3,4} (entry 0 first)
    issue(1, SWAPW, 0, 0, 0, 16'h0004, 1, 1, 16'h0000, 16'h0004, 16'h0000);
    issue(1, ROT,   0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    issue(1, SWAPW, 0, 0, 0, 16'h0003, 1, 1, 16'h0000, 16'h0003, 16'h0000);
    issue(1, ROT,   0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    issue(1, SWAPW, 0, 0, 0, 16'h0002, 1, 1, 16'h0000, 16'h0002, 16'h0000);
    issue(1, ROT,   0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    issue(1, SWAPW, 0, 0, 0, 16'h0001, 1, 1, 16'h0000, 16'h0001, 16'h0000);

    // ROT k=3 with a competing request at T+1 that must be ignored
    begin
      exp_t e;
      e.cyc = cyc + 3; e.we = 1'b0; e.acc = 16'h0000; e.ts = 16'h0002; e.ta = 16'h0000;
      q4.push_back(e);
      c4 = ROT; b4 = 1'b0; n4 = 2'd2; l4 = 1'b0; a4 = 16'hFFFF; v4 = 1'b1;
      @(posedge clk);
      #1 c4 = SWAPW; a4 = 16'hFFFF;
      @(negedge clk);
      chk("t4_ready_t1", {31'd0, r4}, 32'd0);
      @(posedge clk);
      #1 v4 = 1'b0;
      @(negedge clk);
      chk("t4_ready_t2", {31'd0, r4}, 32'd0);
      @(negedge clk);
      chk("t4_ready_t3", {31'd0, r4}, 32'd0);
      chk("t4_done_t3", {31'd0, dn4}, 32'd1);
      @(negedge clk);
      chk("t4_ready_t4", {31'd0, r4}, 32'd1);
    end

    issue(1, ROT,  0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, 16'h0001, 16'h0000);
    issue(1, ROT,  0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, 16'h0004, 16'h0000);
    issue(1, ROT,  0, 3, 0, 16'hFFFF, 4, 0, 16'h0000, 16'h0004, 16'h0000);
    issue(1, ROT,  0, 2, 0, 16'hFFFF, 3, 0, 16'h0000, 16'h0001, 16'h0000);
    issue(1, ROTL, 0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, ROTL_ON ? 16'h0002 : 16'h0001, 16'h0000);
    issue(1, ROT,  0, 0, 0, 16'hFFFF, 1, 0, 16'h0000, ROTL_ON ? 16'h0001 : 16'h0004, 16'h0000);

    // Reset during step 2 of a 3-step rotation: no done, everything cleared
    c4 = ROT; b4 = 1'b0; n4 = 2'd2; v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_tops4", {ts4, ta4}, 32'd0);
    chk("rstmid_tops2", {ts2, ta2}, 32'd0);
    chk("rstmid_ready4", {31'd0, r4}, 32'd1);
    chk("rstmid_done4", {31'd0, dn4}, 32'd0);
    chk("rstmid_acc2", {16'd0, ao2}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_done", {31'd0, dn4}, 32'd0);
    end
    chk("post_rst_top4", {16'd0, ts4}, 32'd0);

    chk("q2_drained", q2.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
